// File: rtl/fifo_stream_adapter_pkg.sv
// Shared sizing helpers for the FIFO read-side stream adapter.
package fifo_stream_adapter_pkg;

  localparam int RD_LATENCY_MIN = 1;
  localparam int RD_LATENCY_MAX = 4;

  // Width able to hold a count from 0 up to and including depth.
  function automatic int lvl_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic bit rd_latency_ok(input int lat);
    return (lat >= RD_LATENCY_MIN) && (lat <= RD_LATENCY_MAX);
  endfunction

endpackage

// File: rtl/fifo_stream_adapter_skid_buffer.sv
// Small register FIFO holding words returned by the read FIFO until the
// stream consumer takes them; depth need not be a power of two.
module stream_skid_buffer
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_DEPTH  = 3,
  localparam int LVL_W = lvl_width(BUF_DEPTH),
  localparam int PTR_W = ptr_width(BUF_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_wdata,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [LVL_W-1:0]      o_level
);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);

  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [LVL_W-1:0]      level_q, level_d;
  logic                  pop;

  assign o_valid = (level_q != '0);
  assign o_data  = mem_q[rptr_q];
  assign o_level = level_q;
  assign pop     = o_valid & i_ready;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    if (i_wr) wptr_d = (wptr_q == PTR_LAST) ? '0 : wptr_q + 1'b1;
    if (pop)  rptr_d = (rptr_q == PTR_LAST) ? '0 : rptr_q + 1'b1;
    case ({i_wr, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
    end
  end

  // Storage needs no reset: a slot is only read once level covers it.
  always_ff @(posedge i_clk) begin
    if (i_wr) mem_q[wptr_q] <= i_wdata;
  end

endmodule

// File: rtl/fifo_stream_adapter.sv
// Turns the read side of the dual-clock FIFO into a valid/ready stream.
// Reads are issued against credit (buffered + in-flight) so the skid buffer never overflows.
module fifo_stream_adapter
  import fifo_stream_adapter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int RD_LATENCY = 1,
  parameter int BUF_DEPTH  = RD_LATENCY + 2,
  localparam int LVL_W = lvl_width(BUF_DEPTH)
) (
  input  logic                  i_clk,
  input  logic                  i_srst,
  input  logic                  i_fifo_empty,
  output logic                  o_fifo_re,
  input  logic [DATA_WIDTH-1:0] i_fifo_rdata,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic                  i_ready,
  output logic [LVL_W-1:0]      o_level
);

  localparam logic [LVL_W:0] DEPTH_C = (LVL_W + 1)'(BUF_DEPTH);

  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [LVL_W-1:0]      inflight_q, inflight_d;
  logic [LVL_W-1:0]      level;
  logic                  credit, accepted, retire;

  // Credit uses registered level only, so a pop frees a slot one cycle later
  // and there is no path from i_ready or i_fifo_empty to o_fifo_re.
  assign credit    = ({1'b0, level} + {1'b0, inflight_q}) < DEPTH_C;
  assign o_fifo_re = credit & ~i_srst;
  assign accepted  = o_fifo_re & ~i_fifo_empty;
  assign retire    = pipe_q[RD_LATENCY-1];

  always_comb begin
    pipe_d    = '0;
    pipe_d[0] = accepted;
    for (int i = 1; i < RD_LATENCY; i++) pipe_d[i] = pipe_q[i-1];
  end

  always_comb begin
    inflight_d = inflight_q;
    case ({accepted, retire})
      2'b10:   inflight_d = inflight_q + 1'b1;
      2'b01:   inflight_d = inflight_q - 1'b1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      pipe_q     <= '0;
      inflight_q <= '0;
    end else begin
      pipe_q     <= pipe_d;
      inflight_q <= inflight_d;
    end
  end

  stream_skid_buffer #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_skid (
    .i_clk   (i_clk),
    .i_srst  (i_srst),
    .i_wr    (retire),
    .i_wdata (i_fifo_rdata),
    .i_ready (i_ready),
    .o_valid (o_valid),
    .o_data  (o_data),
    .o_level (level)
  );

  assign o_level = level;

  a_cfg_ok: assert property (@(posedge i_clk)
    rd_latency_ok(RD_LATENCY) && (BUF_DEPTH >= RD_LATENCY + 1));

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_srst)
    ({1'b0, level} + {1'b0, inflight_q}) <= DEPTH_C);

endmodule

// File: doc/fifo_stream_adapter.md
Name: fifo_stream_adapter

Overview:
- Read-side consumer of the dual clock FIFO; runs entirely in the FIFO read clock domain.
- Converts the FIFO read interface (empty flag, read enable, read data returned a fixed number of cycles after a read) into a valid/ready stream with backpressure.
- Tracks reads that are still in flight through a credit count and buffers their returned data in a small register skid buffer.
- Sustains one word per clock when the consumer holds i_ready high.

Parameters:
- DATA_WIDTH, 8, word width; must equal the FIFO DATA_WIDTH.
- RD_LATENCY, 1, cycles from an accepted read to valid i_fifo_rdata; 1 = FIFO without output register, 2 = with output register. Legal range 1..4.
- BUF_DEPTH, RD_LATENCY+2, skid buffer entries; must be >= RD_LATENCY+1. Values below RD_LATENCY+2 reduce throughput.

Ports:
- i_clk, in, 1, FIFO read clock.
- i_srst, in, 1, synchronous active-high reset.
- i_fifo_empty, in, 1, FIFO o_empty.
- o_fifo_re, out, 1, FIFO i_re.
- i_fifo_rdata, in, DATA_WIDTH, FIFO o_rdata.
- o_valid, out, 1, stream word valid.
- o_data, out, DATA_WIDTH, stream word.
- i_ready, in, 1, consumer accepts the word.
- o_level, out, $clog2(BUF_DEPTH+1), buffered word count (excludes in-flight reads).

Behaviour:
- Reset: one clock, synchronous, active-high. While i_srst is high, all state clears on the next edge: o_valid=0, o_level=0, o_fifo_re=0, in-flight pipe=0, buffer pointers=0. o_data is don't-care while o_valid=0.
- Reset mid-operation: in-flight and buffered words are discarded. i_srst must be asserted together with the FIFO reset.
- No combinational loop: the FIFO o_empty depends combinationally on i_re, so o_fifo_re is a function of registered state only and never of i_fifo_empty.
- Read request: o_fifo_re = (level + inflight < BUF_DEPTH).
  - The FIFO gates the read internally.
  - accepted = o_fifo_re & ~i_fifo_empty.
- In-flight pipe:
  - RD_LATENCY-bit shift register; bit 0 <= accepted.
  - When the last stage is 1, i_fifo_rdata is written to buf[wptr] and wptr advances.
  - inflight = popcount of the pipe, kept as a counter: +accepted, -retire.
- Stream output:
  - o_valid = (level != 0); o_data = buf[rptr].
  - pop = o_valid & i_ready; on pop, rptr advances.
  - Words are delivered in FIFO order.
  - While i_ready=0, o_valid and o_data hold stable.
- Level: level_next = level + retire - pop. Simultaneous retire and pop leaves level unchanged.
- Pointer wrap: wptr and rptr wrap modulo BUF_DEPTH (non-power-of-two allowed; compare against BUF_DEPTH-1).
- Overflow impossible by construction: level + inflight <= BUF_DEPTH always. This is an assertion.
- Throughput: a freed slot is reflected in credit one cycle after pop; no path from i_ready to o_fifo_re. With BUF_DEPTH >= RD_LATENCY+2, continuous i_ready=1 with a non-empty FIFO gives one word per cycle.
- Latency: from first i_fifo_empty=0 (credit available) to o_valid=1 is RD_LATENCY+1 cycles.
- Empty FIFO: o_fifo_re may stay high; no read is accepted and no state changes except pop.

Decomposition:
- Shared package: localparams LVL_W=$clog2(BUF_DEPTH+1), PTR_W=$clog2(BUF_DEPTH); helper to validate RD_LATENCY.
- One natural sub-module: stream_skid_buffer, the register FIFO with wptr/rptr/level, write strobe and pop. The top level holds the credit counter and in-flight pipe.

Test Plan:
- Reset then idle: i_srst=1 for 2 cycles, FIFO empty -> o_valid=0, o_level=0, o_fifo_re=1 after release, no accepted reads.
- Streaming, RD_LATENCY=2, BUF_DEPTH=4: preload FIFO with 16 words 0x00..0x0F, i_ready=1 -> first o_valid 3 cycles after release, then 16 consecutive words in order, no bubbles.
- Backpressure: i_ready=0 with a full FIFO -> o_level settles at 4, inflight=0, o_fifo_re=0, o_data=0x00 held. Raise i_ready -> 0x00,0x01,... delivered with no loss or duplication.
- Intermittent ready, RD_LATENCY=1, BUF_DEPTH=3: random 50% i_ready over 200 words -> scoreboard order exact; level+inflight never exceeds 3.
- FIFO runs empty mid-stream: 5 words, then a gap, then 3 words -> 8 words out in order; o_valid drops exactly after word 5 is popped.
- Reset mid-operation: assert i_srst (with FIFO reset) while level=2 and inflight=1 -> next cycle o_valid=0, o_level=0; a subsequent 4-word write delivers exactly those 4 words.
